// File: rtl/quad_window_ctrl.sv
// Sensor-pair quadrature decoder and fixed-length measurement window scheduler.
// Latency: raw sensor change to position update is FILT+3 clocks; the result is latched on the last window cycle.
// Backpressure: the result holds in REPORT with meas_valid high until meas_ready; position tracking never stalls.
module quad_window_ctrl #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16,
  parameter int FILT  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [WIN_W-1:0]        win_len,
  input  logic                    sensor1_data,
  input  logic                    sensor2_data,
  input  logic                    pos_clr,
  output logic signed [CNT_W-1:0] position,
  output logic                    meas_valid,
  input  logic                    meas_ready,
  output logic signed [CNT_W-1:0] meas_steps,
  output logic [7:0]              meas_errors,
  output logic [1:0]              meas_dir,
  output logic                    busy
);

  localparam int FC_W = $clog2(FILT + 1);
  localparam logic [FC_W-1:0]  FILT_MAX = FC_W'(FILT);
  localparam logic [CNT_W-1:0] ST_MAX   = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] ST_MIN   = {1'b1, {(CNT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;

  state_t           state, state_nxt;
  logic [1:0]       sync_meta, sync_code;
  logic [1:0]       cand_code, acc_code;
  logic [FC_W-1:0]  stable_cnt;
  logic             code_valid;
  logic             code_accept;
  logic [1:0]       step_diff;
  logic             step_fwd, step_rev, step_err;
  logic [WIN_W-1:0] win_cnt;
  logic             win_last;
  logic [CNT_W-1:0] win_steps, steps_nxt;
  logic [7:0]       win_errors, errors_nxt;
  logic [1:0]       dir_nxt;

  // Position along the Gray cycle 00,01,11,10 so a step is a difference of +-1 mod 4
  function automatic logic [1:0] gray_idx(input logic [1:0] c);
    return {c[1], c[1] ^ c[0]};
  endfunction

  // Two-flop synchroniser for the asynchronous sensor pair, code = {sensor2, sensor1}
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 2'b00;
      sync_code <= 2'b00;
    end else begin
      sync_meta <= {sensor2_data, sensor1_data};
      sync_code <= sync_meta;
    end
  end

  // Glitch filter: a code must be seen FILT cycles in a row before it is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_code  <= 2'b00;
      stable_cnt <= '0;
      acc_code   <= 2'b00;
      code_valid <= 1'b0;
    end else begin
      if (sync_code != cand_code) begin
        cand_code  <= sync_code;
        stable_cnt <= FC_W'(1);
      end else if (stable_cnt != FILT_MAX) begin
        stable_cnt <= stable_cnt + FC_W'(1);
      end
      if (code_accept) begin
        acc_code   <= cand_code;
        code_valid <= 1'b1;
      end
    end
  end

  // Step decode; the first accepted code after reset only establishes the reference
  always_comb begin
    code_accept = (stable_cnt == FILT_MAX) && (!code_valid || (cand_code != acc_code));
    step_diff   = gray_idx(cand_code) - gray_idx(acc_code);
    step_fwd    = code_accept && code_valid && (step_diff == 2'd1);
    step_rev    = code_accept && code_valid && (step_diff == 2'd3);
    step_err    = code_accept && code_valid && (step_diff == 2'd2);
  end

  // Free-running position, wraps naturally; pos_clr beats a coincident step
  always_ff @(posedge clk) begin
    if (reset || pos_clr) position <= '0;
    else if (step_fwd)    position <= position + CNT_W'(1);
    else if (step_rev)    position <= position - CNT_W'(1);
  end

  // Saturating window accumulators including this cycle's event, plus the direction code
  always_comb begin
    steps_nxt = win_steps;
    if (step_fwd && (win_steps != ST_MAX))      steps_nxt = win_steps + CNT_W'(1);
    else if (step_rev && (win_steps != ST_MIN)) steps_nxt = win_steps - CNT_W'(1);
    errors_nxt = win_errors;
    if (step_err && (win_errors != 8'hFF)) errors_nxt = win_errors + 8'd1;
    if (errors_nxt != 8'd0)            dir_nxt = 2'b10;
    else if (steps_nxt == '0)          dir_nxt = 2'b01;
    else if (steps_nxt[CNT_W-1])       dir_nxt = 2'b00;
    else                               dir_nxt = 2'b11;
    win_last = (win_cnt == WIN_W'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; disabling mid-window aborts and discards the window
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = ARM;
      ARM:     state_nxt = MEASURE;
      MEASURE: begin
        if (!enable)      state_nxt = IDLE;
        else if (win_last) state_nxt = REPORT;
      end
      REPORT:  if (meas_ready) state_nxt = enable ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy       = (state != IDLE);
    meas_valid = (state == REPORT);
  end

  // Window counter, accumulators and result latch; results hold outside the final cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt     <= '0;
      win_steps   <= '0;
      win_errors  <= 8'd0;
      meas_steps  <= '0;
      meas_errors <= 8'd0;
      meas_dir    <= 2'b00;
    end else begin
      case (state)
        ARM: begin
          win_cnt    <= (win_len == '0) ? WIN_W'(1) : win_len;
          win_steps  <= '0;
          win_errors <= 8'd0;
        end
        MEASURE: begin
          win_cnt    <= win_cnt - WIN_W'(1);
          win_steps  <= steps_nxt;
          win_errors <= errors_nxt;
          if (enable && win_last) begin
            meas_steps  <= steps_nxt;
            meas_errors <= errors_nxt;
            meas_dir    <= dir_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_window_ctrl.sv
// Bench for quad_window_ctrl: directed scenarios, a transition table and random windows.
// Sensor codes are driven and held; results are checked against a Gray-step model.
// Consumer readiness is varied to exercise the REPORT hold and abort paths.
module tb_quad_window_ctrl;
  localparam int CNT_W = 16;
  localparam int WIN_W = 16;
  localparam int FILT  = 2;

  logic             clk = 1'b0;
  logic             reset, enable, sensor1_data, sensor2_data, pos_clr, meas_ready;
  logic [WIN_W-1:0] win_len;
  logic [CNT_W-1:0] position, meas_steps;
  logic             meas_valid, busy;
  logic [7:0]       meas_errors;
  logic [1:0]       meas_dir;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         m_pos, m_steps, m_errs;
  logic [1:0] m_code;
  logic [CNT_W-1:0] r_steps;
  logic [7:0]       r_errs;
  logic [1:0]       r_dir;

  typedef struct {
    logic [1:0] from_c;
    logic [1:0] to_c;
    int         steps;
    int         errs;
    logic [1:0] dir;
  } vec_t;
  vec_t vecs [16];

  always #5 clk = ~clk;

  quad_window_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W), .FILT(FILT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .win_len(win_len),
    .sensor1_data(sensor1_data), .sensor2_data(sensor2_data), .pos_clr(pos_clr),
    .position(position), .meas_valid(meas_valid), .meas_ready(meas_ready),
    .meas_steps(meas_steps), .meas_errors(meas_errors), .meas_dir(meas_dir),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Clockwise order is 00,01,11,10; returns +1, -1, 0 (no change) or 99 (both bits changed)
  function automatic int cw_delta(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] seq [4];
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
    if (a == b) return 0;
    for (int i = 0; i < 4; i++) begin
      if (seq[i] == a && seq[(i + 1) % 4] == b) return 1;
      if (seq[i] == b && seq[(i + 1) % 4] == a) return -1;
    end
    return 99;
  endfunction

  function automatic logic [1:0] exp_dir(input int steps, input int errs);
    if (errs > 0)  return 2'b10;
    if (steps > 0) return 2'b11;
    if (steps < 0) return 2'b00;
    return 2'b01;
  endfunction

  task automatic model_move(input logic [1:0] c, input bit counting);
    int d;
    d = cw_delta(m_code, c);
    if (d == 99) begin
      if (counting) m_errs++;
    end else begin
      m_pos = m_pos + d;
      if (counting) m_steps += d;
    end
    m_code = c;
  endtask

  task automatic drive(input logic [1:0] c, input int hold, input bit counting);
    sensor1_data = c[0];
    sensor2_data = c[1];
    model_move(c, counting);
    repeat (hold) tick();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (meas_valid !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("valid_seen", meas_valid, 1);
  endtask

  task automatic start_window(input int wl);
    win_len    = WIN_W'(wl);
    m_steps    = 0;
    m_errs     = 0;
    meas_ready = 1'b1;
    enable     = 1'b1;
  endtask

  task automatic finish_window(input string nm);
    wait_valid();
    enable  = 1'b0;
    r_steps = meas_steps;
    r_errs  = meas_errors;
    r_dir   = meas_dir;
    check({nm, "_steps"}, meas_steps, m_steps & 32'hFFFF);
    check({nm, "_errs"}, meas_errors, (m_errs > 255) ? 255 : m_errs);
    check({nm, "_dir"}, meas_dir, exp_dir(m_steps, m_errs));
    check({nm, "_pos"}, position, m_pos & 32'hFFFF);
    tick();
    tick();
    check({nm, "_idle"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit stable, saw;
    int n;

    vecs[0]  = '{2'b00, 2'b00,  0, 0, 2'b01};
    vecs[1]  = '{2'b00, 2'b01,  1, 0, 2'b11};
    vecs[2]  = '{2'b00, 2'b11,  0, 1, 2'b10};
    vecs[3]  = '{2'b00, 2'b10, -1, 0, 2'b00};
    vecs[4]  = '{2'b01, 2'b00, -1, 0, 2'b00};
    vecs[5]  = '{2'b01, 2'b01,  0, 0, 2'b01};
    vecs[6]  = '{2'b01, 2'b11,  1, 0, 2'b11};
    vecs[7]  = '{2'b01, 2'b10,  0, 1, 2'b10};
    vecs[8]  = '{2'b11, 2'b00,  0, 1, 2'b10};
    vecs[9]  = '{2'b11, 2'b01, -1, 0, 2'b00};
    vecs[10] = '{2'b11, 2'b11,  0, 0, 2'b01};
    vecs[11] = '{2'b11, 2'b10,  1, 0, 2'b11};
    vecs[12] = '{2'b10, 2'b00,  1, 0, 2'b11};
    vecs[13] = '{2'b10, 2'b01,  0, 1, 2'b10};
    vecs[14] = '{2'b10, 2'b11, -1, 0, 2'b00};
    vecs[15] = '{2'b10, 2'b10,  0, 0, 2'b01};

    reset = 1'b1; enable = 1'b0; sensor1_data = 1'b0; sensor2_data = 1'b0;
    pos_clr = 1'b0; meas_ready = 1'b0; win_len = '0;
    repeat (3) tick();
    check("rst_pos", position, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_steps", meas_steps, 0);
    check("rst_errs", meas_errors, 0);
    check("rst_dir", meas_dir, 0);
    reset = 1'b0; m_pos = 0; m_code = 2'b00;
    repeat (8) tick();
    check("ref_no_step", position, 0);

    // eight clockwise steps in one window
    start_window(200);
    drive(2'b01, 10, 1); drive(2'b11, 10, 1); drive(2'b10, 10, 1); drive(2'b00, 10, 1);
    drive(2'b01, 10, 1); drive(2'b11, 10, 1); drive(2'b10, 10, 1); drive(2'b00, 10, 1);
    finish_window("cw8");
    check("cw8_const_steps", r_steps, 8);
    check("cw8_const_dir", r_dir, 2'b11);
    check("cw8_const_pos", position, 8);

    // four anticlockwise steps, then an idle window
    start_window(200);
    drive(2'b10, 10, 1); drive(2'b11, 10, 1); drive(2'b01, 10, 1); drive(2'b00, 10, 1);
    finish_window("acw4");
    check("acw4_const_steps", r_steps, 16'hFFFC);
    check("acw4_const_dir", r_dir, 2'b00);
    check("acw4_const_pos", position, 4);
    start_window(20);
    finish_window("still");
    check("still_const_dir", r_dir, 2'b01);

    // one-cycle glitch is filtered out
    start_window(40);
    sensor1_data = 1'b1; tick(); sensor1_data = 1'b0;
    repeat (5) tick();
    finish_window("glitch");
    check("glitch_const_pos", position, 4);

    // held change: position moves exactly FILT+3 clocks after the input edge
    sensor1_data = 1'b1;
    n = 0;
    while (position == 16'd4 && n < 20) begin
      tick();
      n++;
    end
    check("latency", n, FILT + 3);
    model_move(2'b01, 0);
    check("latency_pos", position, m_pos);
    repeat (4) tick();

    // double-bit jump is an error with no step
    drive(2'b00, 10, 0);
    start_window(40);
    drive(2'b11, 12, 1);
    finish_window("jump");
    check("jump_const_errs", r_errs, 1);
    check("jump_const_dir", r_dir, 2'b10);
    check("jump_const_pos", position, 4);

    // REPORT held with meas_ready low, enable toggling, step outside the window
    win_len = 30; m_steps = 0; m_errs = 0; meas_ready = 1'b0; enable = 1'b1;
    drive(2'b10, 10, 1);
    wait_valid();
    sensor1_data = 1'b0; sensor2_data = 1'b0;
    model_move(2'b00, 0);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5)  enable = 1'b0;
      if (i == 15) enable = 1'b1;
      tick();
      if (meas_valid !== 1'b1 || meas_steps !== 16'd1 || meas_errors !== 8'd0 ||
          meas_dir !== 2'b11) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    check("hold_pos", position, m_pos & 32'hFFFF);
    meas_ready = 1'b1;
    tick();
    check("hs_valid_drop", meas_valid, 0);
    check("hs_rearm_busy", busy, 1);
    check("hs_result_kept", meas_steps, 1);
    tick();
    repeat (3) tick();
    enable = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    saw = 1'b0;
    repeat (60) begin
      tick();
      if (meas_valid) saw = 1'b1;
    end
    check("abort_no_valid", saw, 0);

    // position wrap and pos_clr corner cases
    pos_clr = 1'b1; tick(); pos_clr = 1'b0; m_pos = 0;
    check("clr_pos", position, 0);
    drive(2'b10, 10, 0);
    check("wrap_pos", position, 16'hFFFF);
    sensor1_data = 1'b0; sensor2_data = 1'b0;
    repeat (FILT + 2) tick();
    pos_clr = 1'b1; tick(); pos_clr = 1'b0;
    check("clr_vs_step", position, 0);
    repeat (5) tick();
    check("clr_vs_step_after", position, 0);
    m_code = 2'b00; m_pos = 0;

    // reset while in REPORT
    drive(2'b01, 10, 0);
    win_len = 10; meas_ready = 1'b0; enable = 1'b1;
    wait_valid();
    reset = 1'b1; sensor1_data = 1'b0; sensor2_data = 1'b0;
    tick();
    check("rr_valid", meas_valid, 0);
    check("rr_pos", position, 0);
    check("rr_busy", busy, 0);
    enable = 1'b0;
    tick(); tick();
    reset = 1'b0; m_pos = 0; m_code = 2'b00;
    repeat (8) tick();
    check("rr_ref_pos", position, 0);

    // every code transition, checked against hand-written expectations
    for (int v = 0; v < 16; v++) begin
      drive(vecs[v].from_c, 10, 0);
      start_window(30);
      drive(vecs[v].to_c, 12, 1);
      finish_window($sformatf("tbl%0d", v));
      check($sformatf("tbl%0d_steps_c", v), r_steps, vecs[v].steps & 32'hFFFF);
      check($sformatf("tbl%0d_errs_c", v), r_errs, vecs[v].errs);
      check($sformatf("tbl%0d_dir_c", v), r_dir, vecs[v].dir);
    end

    // random code sequences inside windows sized to contain them
    for (int w = 0; w < 8; w++) begin
      logic [1:0] cq [$];
      int hq [$];
      int nseg, len;
      nseg = $urandom_range(3, 12);
      len = 8;
      for (int i = 0; i < nseg; i++) begin
        cq.push_back(2'($urandom_range(0, 3)));
        hq.push_back($urandom_range(6, 14));
        len += hq[i];
      end
      start_window(len);
      for (int i = 0; i < nseg; i++) drive(cq[i], hq[i], 1);
      finish_window($sformatf("rnd%0d", w));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
